// File: rtl/posit_arb_pkg.sv
// Shared types and the round-robin pick helper for the posit operator arbiter.
package posit_arb_pkg;
    // Tags are sized for the largest supported requester count so tag_t is a single type.
    localparam int N_REQ_MAX = 8;
    localparam int IDX_W     = (N_REQ_MAX > 1) ? $clog2(N_REQ_MAX) : 1;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    // Returns {found, index} of the first set bit scanning ptr, ptr+1, ... modulo n.
    function automatic logic [IDX_W:0] rr_first(input logic [N_REQ_MAX-1:0] req,
                                                input logic [IDX_W-1:0]     ptr,
                                                input int                   n);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = 0; k < N_REQ_MAX; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (k < n && !res[IDX_W] && req[IDX_W'(j)]) res = {1'b1, IDX_W'(j)};
        end
        return res;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus index from a request vector and pointer.
module rr_arbiter
    import posit_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);
    logic [N_REQ_MAX-1:0] req_w;
    logic [IDX_W:0]       pick;

    always_comb begin
        req_w            = '0;
        req_w[N_REQ-1:0] = req;
        pick             = rr_first(req_w, ptr, N_REQ);
        grant_vld        = pick[IDX_W];
        grant_idx        = pick[IDX_W-1:0];
        grant            = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = grant_vld && (grant_idx == IDX_W'(i));
        end
    end
endmodule

// File: rtl/posit_op_arbiter.sv
// Shares one fixed-latency posit operator among N_REQ requesters; tags each issue and
// routes the result back to the originating requester's response slot.
module posit_op_arbiter
    import posit_arb_pkg::*;
#(
    parameter int NBITS  = 4,
    parameter int N_REQ  = 4,
    parameter int OP_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*NBITS-1:0] req_a,
    input  logic [N_REQ*NBITS-1:0] req_b,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [N_REQ*NBITS-1:0] resp_data,
    output logic [NBITS-1:0]       op_a,
    output logic [NBITS-1:0]       op_b,
    output logic                   op_issue,
    input  logic [NBITS-1:0]       op_res,
    output logic [CNT_W-1:0]       issue_count
);
    logic [N_REQ-1:0] busy;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] hs;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    tag_t             tag_pipe [OP_LAT+1];
    tag_t             tail;
    logic [NBITS-1:0] resp_q [N_REQ];

    assign elig      = req_valid & ~busy;
    assign hs        = resp_valid & resp_ready;
    assign tail      = tag_pipe[OP_LAT];
    assign req_ready = grant;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req       (elig),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_resp
        assign resp_data[g*NBITS +: NBITS] = resp_q[g];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr         <= '0;
            busy        <= '0;
            resp_valid  <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_issue    <= 1'b0;
            issue_count <= '0;
            for (int i = 0; i <= OP_LAT; i++) tag_pipe[i] <= '0;
            for (int i = 0; i < N_REQ; i++) resp_q[i] <= '0;
        end else begin
            op_issue    <= grant_vld;
            tag_pipe[0] <= '{vld: grant_vld, idx: grant_idx};
            for (int i = 1; i <= OP_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            if (grant_vld) begin
                ptr <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                if (issue_count != '1) issue_count <= issue_count + 1'b1;
            end
            // A granted requester cannot be handshaking: grant requires it idle.
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i]) begin
                    op_a    <= req_a[i*NBITS +: NBITS];
                    op_b    <= req_b[i*NBITS +: NBITS];
                    busy[i] <= 1'b1;
                end else if (hs[i]) begin
                    busy[i] <= 1'b0;
                end
                if (hs[i]) begin
                    resp_valid[i] <= 1'b0;
                end else if (tail.vld && tail.idx == IDX_W'(i)) begin
                    resp_valid[i] <= 1'b1;
                    resp_q[i]     <= op_res;
                end
            end
        end
    end
endmodule
